// File: rtl/cpu_pkg.sv
// Shared CPU definitions: RISC-V load/store funct3 codes and the data-memory
// responder FSM state type.
package cpu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/m_dmem_responder_if.sv
// Load/store request and response channels between the CPU (master) and the
// data-memory responder (slave).
interface m_dmem_responder_if;

    logic        w_req_valid;
    logic        w_req_ready;
    logic [31:0] w_req_addr;
    logic        w_req_we;
    logic [2:0]  w_req_funct3;
    logic [31:0] w_req_wdata;
    logic        w_rsp_valid;
    logic        w_rsp_ready;
    logic [31:0] w_rsp_rdata;
    logic        w_rsp_err;

    modport master (
        output w_req_valid, w_req_addr, w_req_we, w_req_funct3, w_req_wdata, w_rsp_ready,
        input  w_req_ready, w_rsp_valid, w_rsp_rdata, w_rsp_err
    );

    modport slave (
        input  w_req_valid, w_req_addr, w_req_we, w_req_funct3, w_req_wdata, w_rsp_ready,
        output w_req_ready, w_rsp_valid, w_rsp_rdata, w_rsp_err
    );

endinterface

// File: rtl/m_dmem_responder_lane_ext.sv
// Byte-lane steering for RISC-V loads/stores: byte enables, replicated write
// data, sign/zero-extended load data and misalign/illegal-funct3 detection.
module m_lane_ext
    import cpu_pkg::*;
(
    input  logic [1:0]  w_addr_lo,
    input  logic [2:0]  w_funct3,
    input  logic [31:0] w_wdata,
    input  logic [31:0] w_rword,
    output logic [3:0]  w_be,
    output logic [31:0] w_wdata_sh,
    output logic [31:0] w_rdata_ext,
    output logic        w_err
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rbyte = w_rword[{w_addr_lo, 3'b000} +: 8];
    assign rhalf = w_addr_lo[1] ? w_rword[31:16] : w_rword[15:0];

    // Write data is replicated across lanes; the byte enables pick the live ones.
    always_comb begin
        w_be        = '0;
        w_wdata_sh  = '0;
        w_rdata_ext = '0;
        w_err       = 1'b0;
        case (w_funct3)
            F3_B, F3_BU: begin
                w_be        = 4'b0001 << w_addr_lo;
                w_wdata_sh  = {4{w_wdata[7:0]}};
                w_rdata_ext = w_funct3[2] ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
            end
            F3_H, F3_HU: begin
                if (w_addr_lo[0]) begin
                    w_err = 1'b1;
                end else begin
                    w_be        = w_addr_lo[1] ? 4'b1100 : 4'b0011;
                    w_wdata_sh  = {2{w_wdata[15:0]}};
                    w_rdata_ext = w_funct3[2] ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
                end
            end
            F3_W: begin
                if (w_addr_lo != 2'b00) begin
                    w_err = 1'b1;
                end else begin
                    w_be        = 4'b1111;
                    w_wdata_sh  = w_wdata;
                    w_rdata_ext = w_rword;
                end
            end
            default: w_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/m_dmem_responder.sv
// Handshake data-memory responder: one load/store at a time, result returned
// LATENCY cycles after acceptance on a valid/ready response channel.
module m_dmem_responder
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned LATENCY = 2
) (
    input  logic               w_clk,
    input  logic               w_rst,
    m_dmem_responder_if.slave  bus
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        accept;

    logic [ADDR_W-1:0] idx;
    logic [31:0]       rword;
    logic [31:0]       wdata_sh;
    logic [31:0]       rdata_ext;
    logic [3:0]        be;
    logic              lane_err;

    // Zero at power-up; deliberately untouched by reset.
    logic [3:0][7:0] mem [DEPTH] = '{default: '0};

    assign idx    = bus.w_req_addr[ADDR_W+1:2];
    assign rword  = mem[idx];
    assign accept = (state == IDLE) && !w_rst && bus.w_req_valid;

    assign bus.w_req_ready = (state == IDLE) && !w_rst;
    assign bus.w_rsp_valid = (state == RESP);
    assign bus.w_rsp_rdata = rdata_q;
    assign bus.w_rsp_err   = err_q;

    m_lane_ext u_lane_ext (
        .w_addr_lo   (bus.w_req_addr[1:0]),
        .w_funct3    (bus.w_req_funct3),
        .w_wdata     (bus.w_req_wdata),
        .w_rword     (rword),
        .w_be        (be),
        .w_wdata_sh  (wdata_sh),
        .w_rdata_ext (rdata_ext),
        .w_err       (lane_err)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (bus.w_req_valid) begin
                    if (LATENCY == 1) begin
                        state_n = RESP;
                    end else begin
                        state_n = BUSY;
                        cnt_n   = LAT_M1;
                    end
                end
            end
            BUSY: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) state_n = RESP;
            end
            RESP: begin
                if (bus.w_rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                err_q   <= lane_err;
                rdata_q <= (lane_err || bus.w_req_we) ? '0 : rdata_ext;
            end
        end
    end

    always_ff @(posedge w_clk) begin
        if (accept && bus.w_req_we && !lane_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][i] <= wdata_sh[i*8 +: 8];
            end
        end
    end

endmodule
